// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: start handshake, instruction memory port, decoded fields
// and the branch/halt feedback from decode and the ALU.
interface fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
);
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic [PC_W-1:0]    instr_addr;
    logic [INSTR_W-1:0] instr_rd_data;
    logic               msb;
    logic [2:0]         opCode;
    logic [4:0]         operand;
    logic               instr_valid;
    logic [PC_W-1:0]    exec_pc;
    logic               bne;
    logic               zero;
    logic               halt;
    logic               done;

    modport master (
        input  start, start_addr, instr_rd_data, bne, zero, halt,
        output instr_addr, msb, opCode, operand, instr_valid, exec_pc, done
    );

    modport slave (
        output start, start_addr, instr_rd_data, bne, zero, halt,
        input  instr_addr, msb, opCode, operand, instr_valid, exec_pc, done
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read instruction
// memory, applies bne redirects and halt, and runs the start/done handshake.
module fetch_unit #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DONE} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] instr_addr_q, instr_addr_d;
    logic [PC_W-1:0] exec_pc_q, exec_pc_d;
    logic            done_q, done_d;
    logic            run;

    // PC-relative target; offset is a signed 5-bit field, result wraps at PC_W bits.
    function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                      input logic signed [4:0] offset);
        logic signed [PC_W-1:0] offset_ext;
        offset_ext = {{(PC_W-5){offset[4]}}, offset};
        return pc + $unsigned(offset_ext);
    endfunction

    assign run              = (state_q == RUN);
    assign bus.instr_valid  = run;
    assign bus.instr_addr   = instr_addr_q;
    assign bus.exec_pc      = exec_pc_q;
    assign bus.done         = done_q;
    assign bus.msb          = bus.instr_rd_data[INSTR_W-1];
    assign bus.opCode       = bus.instr_rd_data[INSTR_W-2:INSTR_W-4];
    assign bus.operand      = bus.instr_rd_data[4:0];

    always_comb begin
        state_d      = state_q;
        instr_addr_d = instr_addr_q;
        exec_pc_d    = exec_pc_q;
        done_d       = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    instr_addr_d = bus.start_addr;
                    exec_pc_d    = bus.start_addr;
                    done_d       = 1'b0;
                    state_d      = PRIME;
                end
            end
            PRIME, FLUSH: begin
                // Data arriving this cycle is the first read or wrong-path; keep fetching.
                instr_addr_d = instr_addr_q + PC_W'(1);
                state_d      = RUN;
            end
            RUN: begin
                if (bus.halt) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (bus.bne && !bus.zero) begin
                    instr_addr_d = branch_target(exec_pc_q, $signed(bus.operand));
                    exec_pc_d    = branch_target(exec_pc_q, $signed(bus.operand));
                    state_d      = FLUSH;
                end else begin
                    exec_pc_d    = instr_addr_q;
                    instr_addr_d = instr_addr_q + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            instr_addr_q <= '0;
            exec_pc_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_addr_q <= instr_addr_d;
            exec_pc_q    <= exec_pc_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: event-queue program model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [9:0] start_addr = '0;
    logic zero_v = 1'b0;
    logic force_bne = 1'b0;
    logic [8:0] mem [0:1023];
    int errors = 0;
    int checks = 0;
    logic checking = 1'b0;

    typedef struct packed { logic vld; logic [9:0] pc; } ent_t;
    ent_t q[$];
    logic m_active = 1'b0, m_done = 1'b0, m_valid = 1'b0;
    logic [9:0] m_pc = '0, m_addr = '0;

    fetch_unit_if #(.PC_W(10), .INSTR_W(9)) bus ();

    fetch_unit #(.PC_W(10), .INSTR_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic is_halt(input logic [8:0] ins);
        return ins[8] && ins[7:5] == 3'b111;
    endfunction
    function automatic logic is_bne(input logic [8:0] ins);
        return ins[8] && ins[7:5] == 3'b001;
    endfunction

    assign bus.start      = start;
    assign bus.start_addr = start_addr;
    assign bus.zero       = zero_v;
    assign bus.halt       = is_halt({bus.msb, bus.opCode, bus.operand});
    assign bus.bne        = is_bne({bus.msb, bus.opCode, bus.operand}) | force_bne;

    always @(posedge clk) bus.instr_rd_data <= mem[bus.instr_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 1024; i++) mem[i] = {4'b0000, i[4:0]};
    endtask

    // Model: each accepted start or executed instruction schedules the next
    // presented cycles (bubble entries carry the address being fetched).
    task automatic model_step();
        logic [8:0] ins;
        logic [9:0] t;
        ent_t e;
        if (reset) begin
            q.delete();
            m_active = 1'b0; m_done = 1'b0; m_valid = 1'b0;
            m_pc = '0; m_addr = '0;
            checking = 1'b1;
        end else begin
            if (!m_active) begin
                if (start) begin
                    q.delete();
                    q.push_back('{1'b0, start_addr});
                    q.push_back('{1'b1, start_addr});
                    m_active = 1'b1;
                    m_done = 1'b0;
                end
            end else if (m_valid) begin
                ins = mem[m_pc];
                if (is_halt(ins)) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end else if ((is_bne(ins) || force_bne) && !zero_v) begin
                    t = m_pc + {{5{ins[4]}}, ins[4:0]};
                    q.push_back('{1'b0, t});
                    q.push_back('{1'b1, t});
                end else begin
                    q.push_back('{1'b1, m_pc + 10'd1});
                end
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                m_valid = e.vld;
                m_pc = e.pc;
                m_addr = e.vld ? e.pc + 10'd1 : e.pc;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
            chk("instr_addr", 32'(bus.instr_addr), 32'(m_addr));
            chk("exec_pc", 32'(bus.exec_pc), 32'(m_pc));
            chk("done", 32'(bus.done), 32'(m_done));
            if (m_valid) begin
                chk("msb", 32'(bus.msb), 32'(mem[m_pc][8]));
                chk("opCode", 32'(bus.opCode), 32'(mem[m_pc][7:5]));
                chk("operand", 32'(bus.operand), 32'(mem[m_pc][4:0]));
            end
        end
    end

    task automatic wait_valid_pc(input logic [9:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1 && bus.exec_pc === pc) found = 1'b1;
        end
        chk("wait_valid_pc_found", 32'(found), 32'd1);
    endtask

    task automatic pulse_start(input logic [9:0] a);
        start_addr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        init_mem();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_addr", 32'(bus.instr_addr), 32'd0);
        chk("rst_pc", 32'(bus.exec_pc), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;

        // Straight line from 4, branch at 10 with -3
        mem[10] = {1'b1, 3'b001, 5'b11101};
        zero_v = 1'b0;
        @(negedge clk);
        pulse_start(10'd4);
        chk("prime_valid", 32'(bus.instr_valid), 32'd0);
        chk("prime_addr", 32'(bus.instr_addr), 32'd4);
        @(negedge clk);
        chk("first_valid", 32'(bus.instr_valid), 32'd1);
        chk("first_pc", 32'(bus.exec_pc), 32'd4);
        @(negedge clk);
        chk("second_pc", 32'(bus.exec_pc), 32'd5);
        wait_valid_pc(10'd10);
        @(negedge clk);
        chk("branch_bubble", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        chk("branch_target_pc", 32'(bus.exec_pc), 32'd7);
        zero_v = 1'b1;
        wait_valid_pc(10'd10);
        @(negedge clk);
        chk("nottaken_valid", 32'(bus.instr_valid), 32'd1);
        chk("nottaken_pc", 32'(bus.exec_pc), 32'd11);

        // Halt at 14 of the default program
        mem[14] = {1'b1, 3'b111, 5'b00000};
        wait_valid_pc(10'd14);
        @(negedge clk);
        chk("halt_done", 32'(bus.done), 32'd1);
        chk("halt_valid", 32'(bus.instr_valid), 32'd0);
        chk("halt_addr", 32'(bus.instr_addr), 32'd15);
        @(negedge clk);
        chk("halt_addr_frozen", 32'(bus.instr_addr), 32'd15);

        // Restart from DONE at 0, halt at 6
        init_mem();
        mem[6] = {1'b1, 3'b111, 5'b00000};
        pulse_start(10'd0);
        chk("restart_done_low", 32'(bus.done), 32'd0);
        wait_valid_pc(10'd0);
        wait_valid_pc(10'd6);
        @(negedge clk);
        chk("halt6_done", 32'(bus.done), 32'd1);
        chk("halt6_addr", 32'(bus.instr_addr), 32'd7);

        // Wrap around 1023 and branch -1 from 0
        init_mem();
        mem[0] = {1'b1, 3'b001, 5'b11111};
        mem[3] = {1'b1, 3'b111, 5'b00000};
        zero_v = 1'b0;
        pulse_start(10'd1022);
        @(negedge clk);
        chk("wrap_pc0", 32'(bus.exec_pc), 32'd1022);
        @(negedge clk);
        chk("wrap_pc1", 32'(bus.exec_pc), 32'd1023);
        @(negedge clk);
        chk("wrap_pc2", 32'(bus.exec_pc), 32'd0);
        @(negedge clk);
        chk("wrap_flush_addr", 32'(bus.instr_addr), 32'd1023);
        @(negedge clk);
        chk("wrap_target_pc", 32'(bus.exec_pc), 32'd1023);
        chk("wrap_target_valid", 32'(bus.instr_valid), 32'd1);
        zero_v = 1'b1;
        wait_valid_pc(10'd3);
        @(negedge clk);

        // Start during RUN ignored, then reset mid-RUN
        init_mem();
        mem[40] = {1'b1, 3'b111, 5'b00000};
        pulse_start(10'd20);
        wait_valid_pc(10'd23);
        pulse_start(10'd100);
        chk("ignored_start_pc", 32'(bus.exec_pc), 32'd24);
        wait_valid_pc(10'd26);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
        chk("midrst_addr", 32'(bus.instr_addr), 32'd0);
        chk("midrst_pc", 32'(bus.exec_pc), 32'd0);
        @(negedge clk);
        chk("midrst_idle", 32'(bus.instr_valid), 32'd0);

        // bne forced while invalid; branch straight into halt
        init_mem();
        mem[52] = {1'b1, 3'b001, 5'b00011};
        mem[55] = {1'b1, 3'b111, 5'b00000};
        zero_v = 1'b0;
        pulse_start(10'd50);
        force_bne = 1'b1;
        @(negedge clk);
        force_bne = 1'b0;
        chk("prime_bne_ignored", 32'(bus.exec_pc), 32'd50);
        wait_valid_pc(10'd52);
        @(negedge clk);
        chk("flush_valid", 32'(bus.instr_valid), 32'd0);
        chk("flush_addr", 32'(bus.instr_addr), 32'd55);
        force_bne = 1'b1;
        @(negedge clk);
        force_bne = 1'b0;
        chk("target55_pc", 32'(bus.exec_pc), 32'd55);
        chk("target55_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("target55_halt_done", 32'(bus.done), 32'd1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
